mux_vector_seq: RTL and testbench

Clocked stimulus sequencer and response checker for the 2:1 mux stage. On a start pulse it drives every `{a, b, sel}` combination onto the mux inputs and holds each one for a programmable settle time. It samples the mux output `y` at the end of each hold window and compares it against the expected value `sel ? b : a`. It replaces free-running initial-block stimulus with a repeatable, clock-aligned source that the mux bench can reuse and that reports completion.

---
 rtl/mux_vector_seq.sv | 172 +++++++++++++++++
 tb/tb_mux_vector_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_vector_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mux_vector_seq
//  Purpose  : Clock-aligned stimulus sequencer and response checker for a
//             2:1 mux. A run drives all eight {a, b, sel} combinations.
//             Each combination is held for HOLD_CYCLES cycles and then sampled
//             for one cycle. A run repeats the full sweep REPEAT times.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    HOLD_CYCLES  drive cycles per vector before sampling (1..255)
//    REPEAT       full 8-vector sweeps per run (1..255)
//  Ports
//    clk          rising-edge clock
//    rst          synchronous active-high reset
//    start_i      run request, sampled only while idle
//    y_i          mux output under test
//    a_o, b_o     registered mux data inputs
//    sel_o        registered mux select
//    vec_idx_o    current vector, {a, b, sel} = vec_idx
//    busy_o       run in progress (drive/sample phases)
//    done_o       one-cycle pulse at run completion
//    mismatch_o   registered pulse, y was wrong in the previous sample cycle
//    err_cnt_o    saturating mismatch count of the current/last run
//  Build option
//    MUX_VECTOR_CHECK_EN  when defined, builds the y checker. Otherwise
//                         mismatch_o and err_cnt_o are tied to zero.
// ============================================================================
module mux_vector_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int REPEAT      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       y_i,
    output logic       a_o,
    output logic       b_o,
    output logic       sel_o,
    output logic [2:0] vec_idx_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       mismatch_o,
    output logic [7:0] err_cnt_o
);

    localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] C_PASS_LAST = 8'(REPEAT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] vec_q,   vec_d;
    logic [7:0] pass_q,  pass_d;
    logic [7:0] hold_q,  hold_d;
    logic [2:0] abs_q,   abs_d;     // {a, b, sel} driven onto the mux

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= 3'd0;
            pass_q  <= 8'd0;
            hold_q  <= 8'd0;
            abs_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pass_q  <= pass_d;
            hold_q  <= hold_d;
            abs_q   <= abs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        pass_d  = pass_q;
        hold_d  = hold_q;
        abs_d   = abs_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    vec_d   = 3'd0;
                    pass_d  = 8'd0;
                    hold_d  = 8'd0;
                    abs_d   = 3'd0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                abs_d  = vec_q;
                hold_d = hold_q + 8'd1;
                if (hold_q == C_HOLD_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                // Inputs hold for this cycle; the next vector lands on the
                // same edge that advances vec_idx.
                hold_d = 8'd0;
                if (vec_q == 3'd7) begin
                    vec_d = 3'd0;
                    abs_d = 3'd0;
                    if (pass_q == C_PASS_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        pass_d  = pass_q + 8'd1;
                        state_d = S_DRIVE;
                    end
                end else begin
                    vec_d   = vec_q + 3'd1;
                    abs_d   = vec_q + 3'd1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                abs_d   = 3'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign a_o       = abs_q[2];
    assign b_o       = abs_q[1];
    assign sel_o     = abs_q[0];
    assign vec_idx_o = vec_q;
    assign busy_o    = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done_o    = (state_q == S_DONE);

`ifdef MUX_VECTOR_CHECK_EN
    logic       w_exp_y;
    logic       w_mm;
    logic       w_start_acc;
    logic       mm_q;
    logic [7:0] err_q;

    assign w_exp_y     = abs_q[0] ? abs_q[1] : abs_q[2];
    // Case inequality so that an X or Z on y is reported as wrong.
    assign w_mm        = (state_q == S_SAMPLE) && (y_i !== w_exp_y);
    assign w_start_acc = (state_q == S_IDLE) && start_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            mm_q  <= 1'b0;
            err_q <= 8'd0;
        end else begin
            mm_q <= w_mm;
            if (w_start_acc) begin
                err_q <= 8'd0;
            end else if (w_mm && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign mismatch_o = mm_q;
    assign err_cnt_o  = err_q;
`else
    logic w_unused_y;
    assign w_unused_y = y_i;
    assign mismatch_o = 1'b0;
    assign err_cnt_o  = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_vector_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_vector_seq
//  Purpose  : Self-checking bench for mux_vector_seq. dut0 uses HOLD_CYCLES=4
//             and REPEAT=1. dut1 uses HOLD_CYCLES=1 and REPEAT=2. The bench
//             drives y from a reference mux, a stuck-at-0 source or X.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_vector_seq;

    typedef struct {
        logic [2:0] vec;
        logic       a;
        logic       b;
        logic       sel;
        logic       y;     // correct mux output for this vector
    } vec_t;

    typedef struct {
        logic       busy;
        logic       done;
        logic [2:0] vec;
        logic [2:0] abs;
        logic       mm;
        logic [7:0] err;
    } obs_t;

    vec_t tbl [8];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    int         mode0 = 0, mode1 = 0;   // 0 good mux, 1 stuck-at-0, 2 X
    logic       a0, b0, s0, y0, busy0, done0, mm0;
    logic       a1, b1, s1, y1, busy1, done1, mm1;
    logic [2:0] v0, v1;
    logic [7:0] e0, e1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign y0 = (mode0 == 0) ? (s0 ? b0 : a0) : (mode0 == 1) ? 1'b0 : 1'bx;
    assign y1 = (mode1 == 0) ? (s1 ? b1 : a1) : (mode1 == 1) ? 1'b0 : 1'bx;

    mux_vector_seq #(.HOLD_CYCLES(4), .REPEAT(1)) dut0 (
        .clk(clk), .rst(rst), .start_i(start0), .y_i(y0),
        .a_o(a0), .b_o(b0), .sel_o(s0), .vec_idx_o(v0),
        .busy_o(busy0), .done_o(done0), .mismatch_o(mm0), .err_cnt_o(e0)
    );

    mux_vector_seq #(.HOLD_CYCLES(1), .REPEAT(2)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .y_i(y1),
        .a_o(a1), .b_o(b1), .sel_o(s1), .vec_idx_o(v1),
        .busy_o(busy1), .done_o(done1), .mismatch_o(mm1), .err_cnt_o(e1)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic obs_t get(input int d);
        obs_t o;
        if (d == 0) begin
            o.busy = busy0; o.done = done0; o.vec = v0;
            o.abs = {a0, b0, s0}; o.mm = mm0; o.err = e0;
        end else begin
            o.busy = busy1; o.done = done1; o.vec = v1;
            o.abs = {a1, b1, s1}; o.mm = mm1; o.err = e1;
        end
        return o;
    endfunction

    // Value the bench itself places on y for a given source mode.
    function automatic logic ysrc(input int mode, input int v);
        logic r;
        if (mode == 0)      r = tbl[v].y;
        else if (mode == 1) r = 1'b0;
        else                r = 1'bx;
        return r;
    endfunction

    function automatic logic exp_mm(input int mode, input int v);
`ifdef MUX_VECTOR_CHECK_EN
        logic yv;
        yv = ysrc(mode, v);
        return (yv !== tbl[v].y);
`else
        return 1'b0 & mode[0] & v[0];
`endif
    endfunction

    task automatic set_start(input int d, input logic val);
        if (d == 0) start0 = val; else start1 = val;
    endtask

    // A complete run, called from an idle cycle. It checks every cycle of
    // the run, the DONE cycle and the following IDLE cycle.
    task automatic run(input int d, input int hold, input int rep, input int mode, input bit keep_start);
        obs_t o;
        int   err = 0;
        logic pend = 1'b0;
        logic mm;
        set_start(d, 1'b1);
        @(posedge clk); #1;
        set_start(d, keep_start);
        for (int p = 0; p < rep; p++) begin
            for (int v = 0; v < 8; v++) begin
                for (int k = 0; k <= hold; k++) begin
                    o = get(d);
                    mm = 1'b0;
                    if (k == 0) begin
                        mm = pend;
                        if (pend && err < 255) err++;
                    end
                    check("busy",     16'(o.busy), 16'd1);
                    check("done",     16'(o.done), 16'd0);
                    check("vec_idx",  16'(o.vec),  16'(tbl[v].vec));
                    check("abs",      16'(o.abs),  16'({tbl[v].a, tbl[v].b, tbl[v].sel}));
                    check("mismatch", 16'(o.mm),   16'(mm));
                    check("err_cnt",  16'(o.err),  16'(err));
                    if (k == hold) pend = exp_mm(mode, v);
                    @(posedge clk); #1;
                end
            end
        end
        if (pend && err < 255) err++;
        o = get(d);
        check("done_busy", 16'(o.busy), 16'd0);
        check("done_pls",  16'(o.done), 16'd1);
        check("done_abs",  16'(o.abs),  16'd0);
        check("done_mm",   16'(o.mm),   16'(pend));
        check("done_err",  16'(o.err),  16'(err));
        @(posedge clk); #1;
        o = get(d);
        check("idle_busy", 16'(o.busy), 16'd0);
        check("idle_done", 16'(o.done), 16'd0);
        check("idle_abs",  16'(o.abs),  16'd0);
        check("idle_mm",   16'(o.mm),   16'd0);
        check("idle_err",  16'(o.err),  16'(err));
    endtask

    function automatic int exp_err(input int mode, input int rep);
        int n = 0;
        for (int v = 0; v < 8; v++) if (exp_mm(mode, v)) n++;
        return n * rep;
    endfunction

    initial begin
        obs_t o;
        // {a, b, sel} = vec, y = sel ? b : a, worked out by hand.
        tbl[0] = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{3'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{3'd3, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{3'd4, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{3'd5, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{3'd6, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{3'd7, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            o = get(d);
            check("rst_busy", 16'(o.busy), 16'd0);
            check("rst_done", 16'(o.done), 16'd0);
            check("rst_vec",  16'(o.vec),  16'd0);
            check("rst_abs",  16'(o.abs),  16'd0);
            check("rst_mm",   16'(o.mm),   16'd0);
            check("rst_err",  16'(o.err),  16'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Good mux, stuck-at-0 and X on y with the default timing.
        mode0 = 0; run(0, 4, 1, 0, 1'b0);
        mode0 = 1; run(0, 4, 1, 1, 1'b0);
        check("err_stuck0", 16'(e0), 16'(exp_err(1, 1)));
        mode0 = 2; run(0, 4, 1, 2, 1'b0);
        check("err_x", 16'(e0), 16'(exp_err(2, 1)));

        // Short hold with two passes; vec_idx wraps once inside the run.
        mode1 = 1; run(1, 1, 2, 1, 1'b0);
        check("err_rep2", 16'(e1), 16'(exp_err(1, 2)));

        // start held high throughout. The second run starts only from IDLE,
        // and err_cnt clears when it starts.
        mode0 = 1;
        run(0, 4, 1, 1, 1'b1);
        run(0, 4, 1, 0, 1'b0);

        // Reset in the middle of a run while vec_idx is 4.
        mode0 = 1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("mid_vec", 16'(v0), 16'd4);
        check("mid_err", 16'(e0), 16'(exp_err(1, 1) != 0 ? 1 : 0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        o = get(0);
        check("abort_busy", 16'(o.busy), 16'd0);
        check("abort_abs",  16'(o.abs),  16'd0);
        check("abort_err",  16'(o.err),  16'd0);
        check("abort_done", 16'(o.done), 16'd0);
        check("abort_vec",  16'(o.vec),  16'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_nodone", 16'(done0), 16'd0);
            check("abort_idle",   16'(busy0), 16'd0);
        end
        mode0 = 0; run(0, 4, 1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
